// File: rtl/mem_access_stage_if.sv
// Bus bundle for mem_access_stage: EX request, data-memory port and
// write-back handshake. master = surrounding pipeline, slave = the stage.
interface mem_access_stage_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int REG_W  = 3
);
    logic              ex_valid;
    logic              ex_ready;
    logic              ex_is_load;
    logic              ex_is_store;
    logic [ADDR_W-1:0] ex_addr;
    logic [DATA_W-1:0] ex_wdata;
    logic [DATA_W-1:0] ex_result;
    logic [REG_W-1:0]  ex_rd;
    logic              ex_reg_write;

    logic [ADDR_W-1:0] dm_address;
    logic [DATA_W-1:0] dm_write_data;
    logic              dm_mem_read;
    logic              dm_mem_write;
    logic [DATA_W-1:0] dm_data_out;

    logic              wb_valid;
    logic              wb_ready;
    logic [DATA_W-1:0] wb_data;
    logic [REG_W-1:0]  wb_rd;
    logic              wb_reg_write;
    logic              mem_err;

    modport master (
        output ex_valid, ex_is_load, ex_is_store, ex_addr, ex_wdata,
        output ex_result, ex_rd, ex_reg_write,
        output dm_data_out, wb_ready,
        input  ex_ready, dm_address, dm_write_data, dm_mem_read,
        input  dm_mem_write, wb_valid, wb_data, wb_rd, wb_reg_write,
        input  mem_err
    );

    modport slave (
        input  ex_valid, ex_is_load, ex_is_store, ex_addr, ex_wdata,
        input  ex_result, ex_rd, ex_reg_write,
        input  dm_data_out, wb_ready,
        output ex_ready, dm_address, dm_write_data, dm_mem_read,
        output dm_mem_write, wb_valid, wb_data, wb_rd, wb_reg_write,
        output mem_err
    );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access stage: one op in flight, registered memory port, wb handshake.
// Optional MEM_ADDR_CHECK_EN rejects the all-ones address and sets sticky mem_err.
module mem_access_stage #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int REG_W  = 3
) (
    input logic clk,
    input logic rst_n,
    mem_access_stage_if.slave bus
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RD_ISSUE = 2'd1;
    localparam logic [1:0] RD_WAIT  = 2'd2;
    localparam logic [1:0] WR_ISSUE = 2'd3;

    logic [1:0]       state;
    logic [REG_W-1:0] ld_rd;
    logic             ld_bad;
    logic             accept;
    logic             is_ld;
    logic             is_st;
    logic             addr_bad;

    assign bus.ex_ready = (state == IDLE) & (~bus.wb_valid | bus.wb_ready);
    assign accept       = bus.ex_valid & bus.ex_ready;
    // load+store together is treated as a plain ALU op
    assign is_ld        = bus.ex_is_load & ~bus.ex_is_store;
    assign is_st        = bus.ex_is_store & ~bus.ex_is_load;

`ifdef MEM_ADDR_CHECK_EN
    assign addr_bad = (bus.ex_addr == {ADDR_W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bus.mem_err <= 1'b0;
        else if (accept && (is_ld || is_st) && addr_bad)
            bus.mem_err <= 1'b1;
    end
`else
    assign addr_bad    = 1'b0;
    assign bus.mem_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            ld_rd             <= '0;
            ld_bad            <= 1'b0;
            bus.dm_address    <= '0;
            bus.dm_write_data <= '0;
            bus.dm_mem_read   <= 1'b0;
            bus.dm_mem_write  <= 1'b0;
            bus.wb_valid      <= 1'b0;
            bus.wb_data       <= '0;
            bus.wb_rd         <= '0;
            bus.wb_reg_write  <= 1'b0;
        end else begin
            if (bus.wb_valid && bus.wb_ready)
                bus.wb_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        unique case (1'b1)
                            is_ld: begin
                                bus.dm_address  <= bus.ex_addr;
                                bus.dm_mem_read <= ~addr_bad;
                                ld_rd           <= bus.ex_rd;
                                ld_bad          <= addr_bad;
                                state           <= RD_ISSUE;
                            end
                            is_st: begin
                                bus.dm_address    <= bus.ex_addr;
                                bus.dm_write_data <= bus.ex_wdata;
                                bus.dm_mem_write  <= ~addr_bad;
                                state             <= WR_ISSUE;
                            end
                            default: begin
                                bus.wb_data      <= bus.ex_result;
                                bus.wb_rd        <= bus.ex_rd;
                                bus.wb_reg_write <= bus.ex_reg_write;
                                bus.wb_valid     <= 1'b1;
                            end
                        endcase
                    end
                end
                RD_ISSUE: begin
                    bus.dm_mem_read <= 1'b0;
                    state           <= RD_WAIT;
                end
                RD_WAIT: begin
                    // wb register is free here: ex_ready gated the accept
                    bus.wb_data      <= ld_bad ? {DATA_W{1'b0}}
                                               : bus.dm_data_out;
                    bus.wb_rd        <= ld_rd;
                    bus.wb_reg_write <= 1'b1;
                    bus.wb_valid     <= 1'b1;
                    state            <= IDLE;
                end
                WR_ISSUE: begin
                    bus.dm_mem_write <= 1'b0;
                    state            <= IDLE;
                end
            endcase
        end
    end
endmodule
